// File: rtl/cdc_pkg.sv
// Purpose: shared definitions for the two-phase toggle request/ack bus synchronizer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds the receive-FSM state encodings and the default bus/counter widths.
// The source-side sender uses the same widths, so both ends of the crossing agree.
package cdc_pkg;

    // Receive FSM state encodings.
    // IDLE means no word is held. VALID means dout holds an unconsumed word.
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_VALID = 1'b1;

    // Default widths shared by the sender and the receiver.
    localparam int DEFAULT_BUS_WIDTH = 8;
    localparam int DEFAULT_CNT_WIDTH = 8;

endpackage : cdc_pkg

// File: rtl/toggle_edge_detect.sv
// Purpose: turns a level-toggle signal into a single-cycle pulse on each change.
// Latency: the pulse is combinational in the cycle the toggle is first seen, relative to the held copy.
// Backpressure: none; every toggle produces exactly one pulse.
//
// Ports:
//   clk       in   single clock, all logic on posedge
//   rst       in   synchronous, active-high; clears the held copy to 0
//   toggle_i  in   toggle input (already synchronized into clk's domain)
//   prev_o    out  registered copy of toggle_i from the previous cycle
//   pulse_o   out  high for one cycle whenever toggle_i differs from prev_o
//
// The held copy resets to 0. A toggle input that is already 1 right after
// reset therefore counts as an edge. This is intentional: it matches a source
// that toggled once immediately after the shared reset.
module toggle_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic toggle_i,
    output logic prev_o,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= toggle_i;
        end
    end

    assign prev_o  = prev_q;
    assign pulse_o = toggle_i ^ prev_q;

endmodule : toggle_edge_detect

// File: rtl/handshake_sync_receiver.sv
// Purpose: destination-side receive stage of a two-phase toggle req/ack bus synchronizer.
// Latency: word appears on dout/dout_valid one cycle after the req edge; ack toggles one cycle after acceptance.
// Backpressure: dout_ready low holds the word and withholds the ack; req edges while holding are dropped and flagged.
//
// Ports:
//   clk           in   destination-domain clock
//   rst           in   synchronous, active-high reset
//   req_sync      in   request toggle, already through the multi-flop synchronizer
//   async_data    in   source data bus; held stable by the source until it sees our ack
//   dout          out  captured word
//   dout_valid    out  dout holds an unconsumed word
//   dout_ready    in   consumer accepts dout when high together with dout_valid
//   ack_toggle    out  acknowledge toggle back to the source domain
//   protocol_err  out  sticky; a req edge arrived while a word was outstanding
//   xfer_cnt      out  accepted words, modulo 2^CNT_WIDTH
//
// All outputs come straight from flops. No input reaches an output in the same cycle.
module handshake_sync_receiver
    import cdc_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_sync,
    input  logic [BUS_WIDTH-1:0] async_data,
    output logic [BUS_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 ack_toggle,
    output logic                 protocol_err,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    // ------------------------------------------------------------------
    // Request edge detection
    // ------------------------------------------------------------------
    logic req_prev;
    logic req_edge;

    toggle_edge_detect u_req_edge (
        .clk      (clk),
        .rst      (rst),
        .toggle_i (req_sync),
        .prev_o   (req_prev),
        .pulse_o  (req_edge)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic                 state_q,  state_d;
    logic [BUS_WIDTH-1:0] dout_q,   dout_d;
    logic                 ack_q,    ack_d;
    logic                 err_q,    err_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;

    logic accept;
    assign accept = (state_q == ST_VALID) && dout_ready;

    // Process 1: state register. The datapath registers share its reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Process 2: next-state and datapath update.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ack_d   = ack_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // async_data is only looked at here. The source guarantees
                // it is stable from its toggle until it sees our ack.
                if (req_edge) begin
                    dout_d  = async_data;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // An edge while holding a word is a source protocol error.
                // The new word is dropped and gets no ack. Acceptance still
                // proceeds normally, even when it happens in the same cycle.
                if (req_edge) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    state_d = ST_IDLE;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Process 3: outputs. Every output is a flop or decoded from the state flop.
    always_comb begin
        dout_valid   = (state_q == ST_VALID);
        dout         = dout_q;
        ack_toggle   = ack_q;
        protocol_err = err_q;
        xfer_cnt     = cnt_q;
    end

endmodule : handshake_sync_receiver

// File: tb/tb_handshake_sync_receiver.sv
module tb_handshake_sync_receiver;

    logic       clk;
    logic       rst;
    logic       req_sync;
    logic [7:0] async_data;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       ack_toggle;
    logic       protocol_err;
    logic [7:0] xfer_cnt;

    handshake_sync_receiver #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_sync     (req_sync),
        .async_data   (async_data),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .ack_toggle   (ack_toggle),
        .protocol_err (protocol_err),
        .xfer_cnt     (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Words the consumer is expected to accept, in order.
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after posedge. Direct checks are also made there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted word is compared against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dout_valid && dout_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_underflow: accepted 0x%0h, expected no word", dout);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (dout === e) passed++;
                    else $display("FAIL sb_data: got 0x%0h, expected 0x%0h", dout, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_sync = 1'b0; async_data = 8'h00; dout_ready = 1'b0;
        tick(); tick();
        chk("rst_dout",  dout, 0);
        chk("rst_vld",   dout_valid, 0);
        chk("rst_ack",   ack_toggle, 0);
        chk("rst_err",   protocol_err, 0);
        chk("rst_cnt",   xfer_cnt, 0);
        rst = 1'b0;
        tick();
        chk("idle_vld", dout_valid, 0);

        // Basic transfer with ready held high.
        async_data = 8'hA5; dout_ready = 1'b1; req_sync = 1'b1; exp_q.push_back(8'hA5);
        tick();
        chk("t1_vld", dout_valid, 1);
        chk("t1_dout", dout, 8'hA5);
        tick();
        chk("t1_vld_low", dout_valid, 0);
        chk("t1_ack", ack_toggle, 1);
        chk("t1_cnt", xfer_cnt, 1);

        // Backpressure: hold for 5 cycles with ready low.
        dout_ready = 1'b0; async_data = 8'h3C; req_sync = 1'b0; exp_q.push_back(8'h3C);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", dout_valid, 1);
            chk("bp_dout", dout, 8'h3C);
            chk("bp_ack", ack_toggle, 1);
            tick();
        end
        dout_ready = 1'b1;
        chk("bp_ack_hold", ack_toggle, 1);
        tick();
        chk("bp_vld_low", dout_valid, 0);
        chk("bp_ack", ack_toggle, 0);
        chk("bp_cnt", xfer_cnt, 2);

        // Protocol violation: a second toggle while 8'h11 is held.
        dout_ready = 1'b0; async_data = 8'h11; req_sync = 1'b1; exp_q.push_back(8'h11);
        tick();
        chk("pv_dout0", dout, 8'h11);
        async_data = 8'hFF; req_sync = 1'b0;
        tick();
        chk("pv_err", protocol_err, 1);
        chk("pv_dout", dout, 8'h11);
        chk("pv_vld", dout_valid, 1);
        dout_ready = 1'b1;
        tick();
        chk("pv_vld_low", dout_valid, 0);
        chk("pv_ack", ack_toggle, 1);
        chk("pv_cnt", xfer_cnt, 3);
        tick(); tick(); tick();
        chk("pv_one_ack", ack_toggle, 1);
        chk("pv_no_recap", dout_valid, 0);
        chk("pv_err_sticky", protocol_err, 1);

        // Reset mid-transfer. The source is reset in the same event.
        dout_ready = 1'b0; async_data = 8'h77; req_sync = 1'b1;
        tick();
        chk("rm_vld", dout_valid, 1);
        rst = 1'b1; req_sync = 1'b0;
        tick();
        chk("rm_dout", dout, 0);
        chk("rm_vld0", dout_valid, 0);
        chk("rm_ack", ack_toggle, 0);
        chk("rm_err", protocol_err, 0);
        chk("rm_cnt", xfer_cnt, 0);
        rst = 1'b0;
        tick();
        async_data = 8'h5A; dout_ready = 1'b1; req_sync = 1'b1; exp_q.push_back(8'h5A);
        tick();
        chk("rm_recap_vld", dout_valid, 1);
        chk("rm_recap_dout", dout, 8'h5A);
        tick();
        chk("rm_recap_ack", ack_toggle, 1);
        chk("rm_recap_cnt", xfer_cnt, 1);

        // Counter wrap: 256 back-to-back handshakes starting from reset.
        rst = 1'b1; req_sync = 1'b0;
        tick();
        rst = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            async_data = i[7:0]; req_sync = ~req_sync; exp_q.push_back(i[7:0]);
            tick();
            tick();
            if (i == 127) chk("wrap_mid_cnt", xfer_cnt, 128);
        end
        chk("wrap_cnt", xfer_cnt, 0);
        chk("wrap_ack", ack_toggle, 0);
        chk("wrap_err", protocol_err, 0);

        // An edge in the same cycle as acceptance: the new word is dropped.
        dout_ready = 1'b0; async_data = 8'hC3; req_sync = 1'b1; exp_q.push_back(8'hC3);
        tick();
        chk("sc_dout", dout, 8'hC3);
        dout_ready = 1'b1; async_data = 8'h99; req_sync = 1'b0;
        tick();
        chk("sc_err", protocol_err, 1);
        chk("sc_vld", dout_valid, 0);
        chk("sc_ack", ack_toggle, 1);
        chk("sc_cnt", xfer_cnt, 1);
        tick();
        chk("sc_dropped", dout_valid, 0);
        chk("sc_dout_keep", dout, 8'hC3);

        // Data stability: the bus changes after the edge is captured.
        dout_ready = 1'b0; async_data = 8'hD2; req_sync = 1'b1; exp_q.push_back(8'hD2);
        tick();
        tick();
        async_data = 8'hE7;
        tick(); tick();
        chk("ds_dout", dout, 8'hD2);
        chk("ds_vld", dout_valid, 1);
        dout_ready = 1'b1;
        tick();
        chk("ds_vld_low", dout_valid, 0);
        chk("ds_cnt", xfer_cnt, 2);

        tick(); tick();
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_handshake_sync_receiver
